// File: rtl/tmr_bank_ctrl.sv
// Arbitrates host writes against voted-value repair of a TMR register bank and logs faults.
// Host write: one WE cycle after acceptance; repair takes p_repairCycles+1 cycles; host_ready drops while busy or a repair is pending.
module tmr_bank_ctrl #(
   parameter int p_numRegs      = 8,
   parameter int p_dataSize     = 32,
   parameter int p_repairCycles = 2,
   parameter int p_irqThreshold = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         host_valid,
   output logic                         host_ready,
   input  logic [$clog2(p_numRegs)-1:0] host_addr,
   input  logic [p_dataSize-1:0]        host_data,
   input  logic [p_numRegs-1:0]         err_in,
   input  logic                         clr_err,
   output logic [p_numRegs-1:0]         reg_we,
   output logic [p_dataSize-1:0]        reg_wdata,
   output logic [p_numRegs-1:0]         err_sticky,
   output logic [p_numRegs-1:0]         persist_fault,
   output logic [7:0]                   err_count,
   output logic                         irq
);

   localparam int c_aw = $clog2(p_numRegs);
   localparam int c_cw = $clog2(p_repairCycles + 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_REPAIR, S_VERIFY} state_t;

   state_t                  r_state, w_next;
   logic [p_numRegs-1:0]    r_err_q;
   logic [p_numRegs-1:0]    r_sticky;
   logic [p_numRegs-1:0]    r_persist;
   logic [7:0]              r_err_count;
   logic                    r_irq;
   logic [c_aw-1:0]         r_addr;
   logic [c_aw-1:0]         r_idx;
   logic [p_dataSize-1:0]   r_data;
   logic [c_cw-1:0]         r_cnt;

   logic [p_numRegs-1:0]    w_pending;
   logic [c_aw-1:0]         w_low_idx;
   logic                    w_accept;
   logic                    w_start_rep;
   logic                    w_verify_hit;
   logic [p_numRegs-1:0]    w_we;

   // Persistently faulted registers are masked so a stuck error cannot starve the host.
   assign w_pending = r_err_q & ~r_persist;

   always_comb begin
      w_low_idx = '0;
      for (int i = p_numRegs - 1; i >= 0; i--) begin
         if (w_pending[i]) w_low_idx = c_aw'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      w_start_rep  = 1'b0;
      w_verify_hit = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_pending) begin
               w_start_rep = 1'b1;
               w_next      = S_REPAIR;
            end else if (host_valid) begin
               w_accept = 1'b1;
               w_next   = S_WRITE;
            end
         end
         S_WRITE:  w_next = S_IDLE;
         S_REPAIR: if (r_cnt == c_cw'(1)) w_next = S_VERIFY;
         S_VERIFY: begin
            w_verify_hit = r_err_q[r_idx];
            w_next       = S_IDLE;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_q <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_err_q <= err_in;
         if (w_accept) begin
            r_addr <= host_addr;
            r_data <= host_data;
         end
         if (w_start_rep) begin
            r_idx <= w_low_idx;
            r_cnt <= c_cw'(p_repairCycles);
         end else if (r_state == S_REPAIR) begin
            r_cnt <= r_cnt - c_cw'(1);
         end
      end
   end

   // A clear in the same cycle as a new fault or count increment takes precedence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky    <= '0;
         r_persist   <= '0;
         r_err_count <= '0;
         r_irq       <= 1'b0;
      end else if (clr_err) begin
         r_sticky    <= '0;
         r_persist   <= '0;
         r_err_count <= '0;
         r_irq       <= 1'b0;
      end else begin
         if (w_start_rep) begin
            r_sticky[w_low_idx] <= 1'b1;
            if (r_err_count != 8'hFF) begin
               r_err_count <= r_err_count + 8'd1;
               if (r_err_count + 8'd1 == 8'(p_irqThreshold)) r_irq <= 1'b1;
            end
         end
         if (w_verify_hit) begin
            r_persist[r_idx] <= 1'b1;
            r_irq            <= 1'b1;
         end
      end
   end

   // Out-of-range host addresses complete the handshake without pulsing any WE.
   always_comb begin
      w_we = '0;
      if (r_state == S_WRITE && 32'(r_addr) < p_numRegs) w_we[r_addr] = 1'b1;
   end

   assign host_ready    = (r_state == S_IDLE) & ~|w_pending;
   assign reg_we        = w_we;
   assign reg_wdata     = r_data;
   assign err_sticky    = r_sticky;
   assign persist_fault = r_persist;
   assign err_count     = r_err_count;
   assign irq           = r_irq;

endmodule

// File: tb/tb_tmr_bank_ctrl.sv
// Randomized and directed bench for tmr_bank_ctrl, checked every cycle against a timeline model.
module tb_tmr_bank_ctrl;

   localparam int N   = 8;
   localparam int W   = 32;
   localparam int R   = 2;
   localparam int THR = 16;
   localparam int AW  = $clog2(N);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           host_valid = 1'b0;
   logic           host_ready;
   logic [AW-1:0]  host_addr = '0;
   logic [W-1:0]   host_data = '0;
   logic [N-1:0]   err_in = '0;
   logic           clr_err = 1'b0;
   logic [N-1:0]   reg_we;
   logic [W-1:0]   reg_wdata;
   logic [N-1:0]   err_sticky;
   logic [N-1:0]   persist_fault;
   logic [7:0]     err_count;
   logic           irq;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: a busy timer per job instead of a state machine.
   logic [N-1:0]   m_errq, m_sticky, m_persist;
   int             m_count;
   bit             m_irq;
   int             m_timer;     // cycles left in current job, 0 = idle
   bit             m_job_wr;
   int             m_addr;
   int             m_idx;
   logic [W-1:0]   m_data;

   tmr_bank_ctrl #(
      .p_numRegs(N), .p_dataSize(W), .p_repairCycles(R), .p_irqThreshold(THR)
   ) dut (
      .clk(clk), .rst(rst),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_addr(host_addr), .host_data(host_data),
      .err_in(err_in), .clr_err(clr_err),
      .reg_we(reg_we), .reg_wdata(reg_wdata),
      .err_sticky(err_sticky), .persist_fault(persist_fault),
      .err_count(err_count), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_errq = '0; m_sticky = '0; m_persist = '0;
      m_count = 0; m_irq = 0; m_timer = 0; m_job_wr = 0;
      m_addr = 0; m_idx = 0; m_data = '0;
   endtask

   function automatic logic [N-1:0] exp_we();
      logic [N-1:0] v;
      v = '0;
      if (m_timer > 0 && m_job_wr && m_addr < N) v[m_addr] = 1'b1;
      return v;
   endfunction

   task automatic model_advance(input bit hv, input int ha, input logic [W-1:0] hd,
                                input logic [N-1:0] ei, input bit ce);
      logic [N-1:0] pend;
      pend = m_errq & ~m_persist;
      if (m_timer == 0) begin
         if (pend != 0) begin
            for (int i = N - 1; i >= 0; i--) if (pend[i]) m_idx = i;
            m_sticky[m_idx] = 1'b1;
            if (m_count < 255) begin
               m_count++;
               if (m_count == THR) m_irq = 1;
            end
            m_job_wr = 0;
            m_timer  = R + 1;
         end else if (hv) begin
            m_job_wr = 1;
            m_timer  = 1;
            m_addr   = ha;
            m_data   = hd;
         end
      end else begin
         if (!m_job_wr && m_timer == 1 && m_errq[m_idx]) begin
            m_persist[m_idx] = 1'b1;
            m_irq = 1;
         end
         m_timer--;
      end
      m_errq = ei;
      if (ce) begin
         m_sticky = '0; m_persist = '0; m_count = 0; m_irq = 0;
      end
   endtask

   task automatic check_all();
      chk("reg_we", reg_we, exp_we());
      chk("reg_wdata", reg_wdata, m_data);
      chk("host_ready", host_ready, (m_timer == 0 && (m_errq & ~m_persist) == 0));
      chk("err_sticky", err_sticky, m_sticky);
      chk("persist_fault", persist_fault, m_persist);
      chk("err_count", err_count, m_count);
      chk("irq", irq, m_irq);
   endtask

   task automatic step(input bit hv, input int ha, input logic [W-1:0] hd,
                       input logic [N-1:0] ei, input bit ce);
      host_valid = hv; host_addr = ha[AW-1:0]; host_data = hd;
      err_in = ei; clr_err = ce;
      model_advance(hv, ha, hd, ei, ce);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
   endtask

   // Raises rst asynchronously; outputs must already be at reset values before any clock edge.
   task automatic do_reset();
      host_valid = 0; err_in = '0; clr_err = 0;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("rst_we_lit", reg_we, 0);
      chk("rst_ready_lit", host_ready, 1);
      chk("rst_cnt_lit", err_count, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] held, ei;
      model_reset();
      #3;
      do_reset();
      check_all();

      // Host writes.
      step(1, 3, 32'hDEADBEEF, '0, 0);
      chk("wr3_we_lit", reg_we, 8'h08);
      chk("wr3_data_lit", reg_wdata, 32'hDEADBEEF);
      chk("wr3_ready_lit", host_ready, 0);
      idle(1);
      step(1, 5, 32'h12345678, '0, 0);
      chk("wr5_we_lit", reg_we, 8'h20);
      chk("wr5_data_lit", reg_wdata, 32'h12345678);
      idle(1);

      // Single correctable error on register 2.
      step(0, 0, '0, 8'h04, 0);
      chk("err2_ready_lit", host_ready, 0);
      idle(1);
      chk("err2_sticky_lit", err_sticky, 8'h04);
      chk("err2_cnt_lit", err_count, 1);
      chk("err2_we_lit", reg_we, 0);
      idle(3);
      chk("err2_persist_lit", persist_fault, 0);
      chk("err2_irq_lit", irq, 0);
      chk("err2_ready_after_lit", host_ready, 1);

      // Stuck error on register 6 becomes persistent and is then ignored.
      for (int i = 0; i < 6; i++) step(0, 0, '0, 8'h40, 0);
      chk("p6_persist_lit", persist_fault, 8'h40);
      chk("p6_irq_lit", irq, 1);
      chk("p6_cnt_lit", err_count, 2);
      chk("p6_ready_lit", host_ready, 1);
      step(1, 6, 32'hA5A5_0006, 8'h40, 0);
      chk("p6_wr_we_lit", reg_we, 8'h40);
      step(0, 0, '0, 8'h40, 0);
      chk("p6_cnt_stay_lit", err_count, 2);
      step(0, 0, '0, '0, 1);
      chk("clr_persist_lit", persist_fault, 0);

      // Two flagged registers racing a host write.
      step(0, 0, '0, 8'h81, 0);
      for (int i = 0; i < 4; i++) step(1, 2, 32'hCAFE_0002, 8'h80, 0);
      for (int i = 0; i < 5; i++) step(1, 2, 32'hCAFE_0002, '0, 0);
      chk("race_we_lit", reg_we, 8'h04);
      chk("race_cnt_lit", err_count, 2);
      chk("race_sticky_lit", err_sticky, 8'h81);
      idle(2);
      step(0, 0, '0, '0, 1);

      // IRQ threshold and clear-vs-increment.
      for (int k = 0; k < THR; k++) begin
         step(0, 0, '0, N'(1) << (k % N), 0);
         idle(4);
         if (k == THR - 2) chk("thr_minus1_irq_lit", irq, 0);
      end
      chk("thr_cnt_lit", err_count, 16);
      chk("thr_irq_lit", irq, 1);
      chk("thr_model_lit", m_count, 16);
      step(0, 0, '0, 8'h10, 0);
      step(0, 0, '0, '0, 1);
      chk("clr_win_cnt_lit", err_count, 0);
      chk("clr_win_irq_lit", irq, 0);
      idle(4);

      // Saturation at 255.
      for (int k = 0; k < 260; k++) begin
         step(0, 0, '0, N'(1) << (k % N), 0);
         idle(4);
      end
      chk("sat_cnt_lit", err_count, 255);
      chk("sat_model_lit", m_count, 255);
      chk("sat_irq_lit", irq, 1);

      // Asynchronous reset mid-REPAIR and mid-WRITE.
      step(0, 0, '0, 8'h02, 0);
      idle(1);
      #3;
      do_reset();
      chk("rstrep_sticky_lit", err_sticky, 0);
      step(1, 1, 32'h0BAD_F00D, '0, 0);
      chk("rstwr_pre_we_lit", reg_we, 8'h02);
      #3;
      do_reset();
      idle(1);
      chk("rstwr_ready_lit", host_ready, 1);

      // Randomized traffic.
      held = '0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 199) == 0) held = N'(1) << $urandom_range(0, N - 1);
         if ($urandom_range(0, 99) == 0)  held = '0;
         ei = held;
         if ($urandom_range(0, 11) == 0) ei |= N'($urandom);
         step($urandom_range(0, 1) == 1, $urandom_range(0, N - 1), $urandom,
              ei, $urandom_range(0, 63) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
